// File: rtl/out_uart_if.sv
// Byte-output port of out_uart: CPU-side write strobe and data, plus the UART line and status.
// The master side (CPU / testbench) drives the byte and the strobes. The slave side (out_uart)
// drives the line and the status flags.
interface out_uart_if;
  logic [7:0] in;       // byte from CPU output, stable while in_en is high
  logic       in_en;    // write strobe, asynchronous to the UART clock
  logic       ovf_clr;  // synchronous clear of ovf
  logic       tx;       // UART serial line, idle high
  logic       busy;     // frame on the line or bytes queued
  logic       full;     // FIFO holds FIFO_DEPTH bytes
  logic       ovf;      // sticky: a byte was dropped

  modport master (
    output in, in_en, ovf_clr,
    input  tx, busy, full, ovf
  );

  modport slave (
    input  in, in_en, ovf_clr,
    output tx, busy, full, ovf
  );
endinterface

// File: rtl/out_uart.sv
// out_uart: captures CPU output bytes (in/in_en) into a FIFO and serialises them as UART frames.
// The default build sends 8N1 frames. Defining OUT_UART_PARITY_EN inserts an even parity bit (8E1).
// in_en comes from another clock domain and is passed through a 2-FF synchroniser and an edge
// detector. The tx output is registered, so the line lags the FSM state by one clock.
module out_uart #(
  parameter int unsigned CLK_HZ     = 16000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  out_uart_if.slave bus
);

  localparam int unsigned Div  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCount = FIFO_DEPTH[PtrW:0];

`ifdef OUT_UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // ---------------------------------------------------------------------------
  // in_en synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic en_s1_q, en_s2_q, en_s3_q;
  logic wr;

  // Two flops for metastability, a third flop to hold the previous value for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      en_s3_q <= 1'b0;
    end else begin
      en_s1_q <= bus.in_en;
      en_s2_q <= en_s1_q;
      en_s3_q <= en_s2_q;
    end
  end

  assign wr = en_s2_q & ~en_s3_q;

  // ---------------------------------------------------------------------------
  // FIFO (pointers carry one extra wrap bit)
  // ---------------------------------------------------------------------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [PtrW:0] wptr_q, rptr_q;
  logic [PtrW:0] count;
  logic        empty, full, pop, push, drop;
  logic [7:0]  head;
  logic        ovf_q;
  state_e      state_q, state_d;

  assign count = wptr_q - rptr_q;
  assign empty = (count == '0);
  assign full  = (count == FullCount);
  assign head  = mem_q[rptr_q[PtrW-1:0]];
  assign pop   = (state_q == StIdle) & ~empty;
  // A pop frees a slot in the same cycle, so a write while full is still accepted.
  assign push  = wr & (~full | pop);
  assign drop  = wr & full & ~pop;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[PtrW-1:0]] <= bus.in;
    end
  end

  // FIFO pointers and the sticky overflow flag. A drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            active_q;
  logic            bit_end;
`ifdef OUT_UART_PARITY_EN
  logic            par_q, par_d;
`endif

  assign bit_end = (cnt_q == CntW'(Div - 1));

  // State, baud counter, shifter and registered line output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
`ifdef OUT_UART_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      // Extends busy over the last stop-bit clock, which tx shows one cycle after the FSM.
      active_q <= (state_q != StIdle);
`ifdef OUT_UART_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Next-state logic; tx_d is the line level for the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CntW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
`ifdef OUT_UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!empty) begin
          shift_d = head;
`ifdef OUT_UART_PARITY_EN
          par_d   = ^head;
`endif
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef OUT_UART_PARITY_EN
      StParity: begin
        tx_d = par_q;
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        tx_d = 1'b1;
        if (bit_end) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign bus.tx   = tx_q;
  assign bus.busy = (state_q != StIdle) | ~empty | active_q;
  assign bus.full = full;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_out_uart.sv
// Self-checking bench for out_uart at CLK_HZ=16 MHz, BAUD=1 MHz (16 clocks per bit).
// A line receiver decodes tx into a queue and compares it with the bytes that were sent;
// per-clock line levels are predicted from the frame layout. Build with +define+OUT_UART_PARITY_EN
// to exercise 8E1 frames.
module tb_out_uart;

  localparam int unsigned CLK_HZ = 16000000;
  localparam int unsigned BAUD   = 1000000;
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef OUT_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic last_par;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];

  out_uart_if bus ();

  out_uart #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected line level e clocks after in_en is first sampled high (isolated byte, idle line).
  function automatic logic exp_tx(input logic [7:0] b, input int e);
    int k;
    if (e < 4) return 1'b1;
    k = (e - 4) / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef OUT_UART_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Line receiver: samples each bit at its centre; abandons a frame if reset intervenes.
  always begin : rx_mon
    logic [10:0] bits;
    logic [7:0]  d;
    logic        ok;
    int          st;
    int          n;
    @(posedge clk); #1;
    if (rst && bus.tx == 1'b0) begin
      st   = cyc;
      ok   = 1'b1;
      bits = '0;
      for (int b = 0; b < NBITS; b++) begin
        n = (b == 0) ? DIV / 2 : DIV;
        for (int j = 0; j < n; j++) begin
          @(posedge clk); #1;
          if (!rst) ok = 1'b0;
        end
        if (!ok) break;
        bits[b] = bus.tx;
      end
      if (ok) begin
        d = bits[8:1];
        check("rx_start", bits[0], 1'b0);
        check("rx_stop", bits[NBITS-1], 1'b1);
`ifdef OUT_UART_PARITY_EN
        check("rx_parity", bits[9], ^d);
`endif
        rx_q.push_back(d);
        start_q.push_back(st);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [7:0] b, input int hi, input int lo);
    bus.in    = b;
    bus.in_en = 1'b1;
    repeat (hi) step();
    bus.in_en = 1'b0;
    repeat (lo) step();
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (bus.busy && n < limit) begin
      step();
      n++;
    end
    check("idle_reached", bus.busy, 1'b0);
    repeat (4) step();
  endtask

  task automatic compare_rx();
    check("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check("rx_byte", rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
    start_q.delete();
  endtask

  // One byte with a 32-clock strobe; checks the line on every clock and the busy edges.
  task automatic frame_check(input logic [7:0] b);
    bus.in    = b;
    bus.in_en = 1'b1;
    for (int e = 0; e <= FRAME + 8; e++) begin
      step();
      if (e == 31) bus.in_en = 1'b0;
      check("tx_line", bus.tx, exp_tx(b, e));
      if (e == 1) check("busy_before_wr", bus.busy, 1'b0);
      if (e == 2) check("busy_on_wr", bus.busy, 1'b1);
      if (e == FRAME + 3) check("busy_last", bus.busy, 1'b1);
      if (e == FRAME + 4) check("busy_fall", bus.busy, 1'b0);
      if (e == 4 + 9 * DIV + DIV / 2) last_par = bus.tx;
    end
    exp_q.push_back(b);
    repeat (4) step();
    compare_rx();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         nb;
    rst         = 1'b0;
    bus.in      = '0;
    bus.in_en   = 1'b0;
    bus.ovf_clr = 1'b0;
    step();

    // Reset held with in_en toggling, then quiet line after release.
    for (int i = 0; i < 20; i++) begin
      bus.in_en = 1'($urandom);
      bus.in    = 8'($urandom);
      step();
      check("reset_outs", {bus.tx, bus.busy, bus.full, bus.ovf}, 4'b1000);
    end
    bus.in_en = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      check("idle_outs", {bus.tx, bus.busy, bus.full, bus.ovf}, 4'b1000);
    end

    // Single byte, exact line timing.
    frame_check(8'h55);

    // Three back-to-back bytes: contiguous frames, one idle clock between.
    pulse(8'h41, 2, 2);
    pulse(8'h42, 2, 2);
    pulse(8'h43, 2, 2);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    wait_idle(4 * FRAME);
    check("starts", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("gap_1", start_q[1] - start_q[0], FRAME + 1);
      check("gap_2", start_q[2] - start_q[1], FRAME + 1);
    end
    compare_rx();

    // Random bursts with random strobe shapes.
    for (int r = 0; r < 4; r++) begin
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        pulse(b, $urandom_range(2, 5), $urandom_range(2, 6));
      end
      wait_idle((nb + 1) * (FRAME + 2));
      compare_rx();
    end

    // Overflow: 18 writes before the first frame ends; 17 fit (16 queued + 1 shifting).
    for (int i = 0; i < 18; i++) begin
      b = 8'($urandom);
      if (i < 17) exp_q.push_back(b);
      pulse(b, 2, 2);
      if (i == 15) check("full_at_16", bus.full, 1'b0);
      if (i == 16) check("full_at_17", {bus.full, bus.ovf}, 2'b10);
      if (i == 17) check("ovf_at_18", {bus.full, bus.ovf}, 2'b11);
    end
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", bus.ovf, 1'b0);
    wait_idle(18 * (FRAME + 2));
    compare_rx();

    // Reset in the middle of a data bit: async clear, no resumed frame.
    bus.in    = 8'hFF;
    bus.in_en = 1'b1;
    for (int e = 0; e < 60; e++) begin
      step();
      if (e == 2) bus.in_en = 1'b0;
    end
    check("busy_mid_frame", bus.busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_reset", {bus.tx, bus.busy, bus.full}, 3'b100);
    repeat (5) step();
    rst = 1'b1;
    nb = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) nb++;
    end
    check("no_resume", nb, 0);
    compare_rx();

`ifdef OUT_UART_PARITY_EN
    frame_check(8'h07);
    check("parity_07", last_par, 1'b1);
    frame_check(8'h03);
    check("parity_03", last_par, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
